addsub_arbiter: RTL and testbench

- Shares one combinational 32-bit adder/subtractor (operands A, B; select SR; result Y) among NREQ requesters.
- Round-robin grant with a per-requester valid/ready request channel and a valid/ready response channel.
- Sequences each operation through issue, capture and response, and holds the adder inputs stable while it evaluates.
- Sits between ALU-side clients (PC increment, address calc, compare unit) and the single shared add_sub instance.

---
 rtl/addsub_arb_pkg.sv | 20 ++
 rtl/addsub_arbiter_if.sv | 41 ++++
 rtl/addsub_arbiter_rr_arbiter.sv | 37 +++
 rtl/addsub_arbiter.sv | 133 +++++++++++++
 tb/tb_addsub_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_arb_pkg.sv
// Shared definitions for the add/sub arbiter: FSM encoding, default sizes,
// and the grant-index width helper.
// Optional feature macro used by the block: ADDSUB_ARB_OVF_EN.
package addsub_arb_pkg;

  localparam int DEF_W    = 32;
  localparam int DEF_NREQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Width of a binary requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request/response and shared-adder bus of the add/sub arbiter.
// slave = arbiter side, master = clients plus the shared adder.
// ADDSUB_ARB_OVF_EN adds the rsp_ovf signal.
interface addsub_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sr;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_y;
  logic [W-1:0]      au_a;
  logic [W-1:0]      au_b;
  logic              au_sr;
  logic [W-1:0]      au_y;
`ifdef ADDSUB_ARB_OVF_EN
  logic              rsp_ovf;

  modport slave (
    input  req_valid, req_a, req_b, req_sr, rsp_ready, au_y,
    output req_ready, rsp_valid, rsp_y, au_a, au_b, au_sr, rsp_ovf
  );
  modport master (
    output req_valid, req_a, req_b, req_sr, rsp_ready, au_y,
    input  req_ready, rsp_valid, rsp_y, au_a, au_b, au_sr, rsp_ovf
  );
`else
  modport slave (
    input  req_valid, req_a, req_b, req_sr, rsp_ready, au_y,
    output req_ready, rsp_valid, rsp_y, au_a, au_b, au_sr
  );
  modport master (
    output req_valid, req_a, req_b, req_sr, rsp_ready, au_y,
    input  req_ready, rsp_valid, rsp_y, au_a, au_b, au_sr
  );
`endif
endinterface

// File: rtl/addsub_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above i_ptr,
// wrapping at NREQ. Outputs a one-hot grant and its binary index.
module rr_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    if (i_en) begin
      for (int k = 0; k < NREQ; k++) begin
        j = int'(i_ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        if (!o_any && i_req[j]) begin
          o_any    = 1'b1;
          o_gnt[j] = 1'b1;
          o_idx    = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one combinational add/sub unit among NREQ requesters.
// IDLE accepts one request (round-robin), ISSUE drives the adder and
// captures its result, RESP holds the result until the owner takes it.
// Define ADDSUB_ARB_OVF_EN to add the signed-overflow flag rsp_ovf.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W,
  localparam int IW  = idx_w(NREQ)
) (
  input logic             clk,
  input logic             rst_n,
  addsub_arbiter_if.slave bus
);

  state_e          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_gnt;
  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic            r_op_sr;
  logic [W-1:0]    r_rsp_y;
  logic [NREQ-1:0] r_rsp_valid;

  logic            w_en;
  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_any;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic            w_sel_sr;
  logic [IW-1:0]   w_ptr_nxt;

  // Accept only in IDLE and never while reset is held, so req_ready is
  // quiet during reset even if clients are already requesting.
  assign w_en = (r_state == IDLE) && rst_n;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  // Operand mux of the winning requester.
  always_comb begin
    w_sel_a  = bus.req_a[int'(w_gnt_idx)*W +: W];
    w_sel_b  = bus.req_b[int'(w_gnt_idx)*W +: W];
    w_sel_sr = bus.req_sr[w_gnt_idx];
  end

  assign w_ptr_nxt = (r_gnt == IW'(NREQ-1)) ? '0 : r_gnt + 1'b1;

  // Op registers double as the adder drive: loaded on accept, cleared on
  // return to IDLE, so the adder sees zeros whenever no op is in flight.
  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_y     = r_rsp_y;
  assign bus.au_a      = r_op_a;
  assign bus.au_b      = r_op_b;
  assign bus.au_sr     = r_op_sr;

  // Main sequencer: accept, evaluate/capture, hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_sr     <= 1'b0;
      r_rsp_y     <= '0;
      r_rsp_valid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
            r_op_sr <= w_sel_sr;
            r_gnt   <= w_gnt_idx;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_rsp_y     <= bus.au_y;
          r_rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;
          r_state     <= RESP;
        end
        RESP: begin
          // Only the owner's rsp_ready counts.
          if (bus.rsp_ready[r_gnt]) begin
            r_rsp_valid <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_sr     <= 1'b0;
            r_ptr       <= w_ptr_nxt;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ADDSUB_ARB_OVF_EN
  logic r_rsp_ovf;
  logic w_ovf;

  // Signed overflow: add overflows when operand signs match and the result
  // sign differs; subtract when operand signs differ and the result sign
  // differs from A.
  always_comb begin
    w_ovf = 1'b0;
    if (r_op_sr)
      w_ovf = (r_op_a[W-1] != r_op_b[W-1]) && (bus.au_y[W-1] != r_op_a[W-1]);
    else
      w_ovf = (r_op_a[W-1] == r_op_b[W-1]) && (bus.au_y[W-1] != r_op_a[W-1]);
  end

  // Captured alongside rsp_y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_rsp_ovf <= 1'b0;
    else if (r_state == ISSUE) r_rsp_ovf <= w_ovf;
  end

  assign bus.rsp_ovf = r_rsp_ovf;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: stimulus pushes expected accepts and
// responses into queues, a monitor pops and compares as the DUT presents them.
module tb_addsub_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        sr;
    logic [31:0] y;
    logic        ovf;
    int          gap;
  } op_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0] rr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  op_t pq[NREQ][$];  // pending operations per requester
  op_t aq[$];        // expected accept order
  op_t rq[$];        // expected response order

  addsub_arbiter_if #(.NREQ(NREQ), .W(W)) bus();

  addsub_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.au_y      = bus.au_sr ? (bus.au_a - bus.au_b) : (bus.au_a + bus.au_b);
  assign bus.rsp_ready = rr;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b,
                      input logic sr, input logic [31:0] y, input logic ovf,
                      input int gap, input bit rsp);
    op_t e;
    e.idx = idx; e.a = a; e.b = b; e.sr = sr; e.y = y; e.ovf = ovf; e.gap = gap;
    pq[idx].push_back(e);
    aq.push_back(e);
    if (rsp) rq.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((aq.size() != 0 || rq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(aq.size() + rq.size()), 64'd0);
    aq.delete();
    rq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requester driver: holds valid/operands until the accept edge has passed.
  initial begin
    logic [NREQ-1:0]   acc, v, s;
    logic [NREQ*W-1:0] a, b;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sr    = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      v = '0; s = '0; a = '0; b = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && pq[i].size() != 0) void'(pq[i].pop_front());
        if (pq[i].size() != 0) begin
          v[i]         = 1'b1;
          a[i*W +: W]  = pq[i][0].a;
          b[i*W +: W]  = pq[i][0].b;
          s[i]         = pq[i][0].sr;
        end
      end
      bus.req_valid = v;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_sr    = s;
    end
  end

  // Monitor: accepts, adder drive during ISSUE, latency and responses.
  initial begin
    op_t cur, e;
    int  last_acc;
    bit  pend_au;
    logic [NREQ-1:0] prev_rv, oh;
    last_acc = 0; pend_au = 0; prev_rv = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend_au = 0;
        prev_rv = '0;
      end else begin
        if (pend_au && cyc == last_acc + 1) begin
          chk("issue_au_a",  64'(bus.au_a),  64'(cur.a));
          chk("issue_au_b",  64'(bus.au_b),  64'(cur.b));
          chk("issue_au_sr", 64'(bus.au_sr), 64'(cur.sr));
          pend_au = 0;
        end
        if (bus.req_ready != '0) begin
          if (aq.size() == 0) begin
            chk("accept_unexpected", 64'(bus.req_ready), 64'd0);
          end else begin
            e  = aq.pop_front();
            oh = NREQ'(1) << e.idx;
            chk("accept_idx", 64'(bus.req_ready), 64'(oh));
            if (e.gap != 0) chk("accept_gap", 64'(cyc - last_acc), 64'(e.gap));
            cur = e;
            pend_au = 1;
          end
          last_acc = cyc;
        end
        if (bus.rsp_valid != '0 && prev_rv == '0)
          chk("rsp_latency", 64'(cyc - last_acc), 64'd2);
        if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
          if (rq.size() == 0) begin
            chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
          end else begin
            e  = rq.pop_front();
            oh = NREQ'(1) << e.idx;
            chk("rsp_valid_idx", 64'(bus.rsp_valid), 64'(oh));
            chk("rsp_y",         64'(bus.rsp_y),     64'(e.y));
            chk("rsp_au_a",      64'(bus.au_a),      64'(e.a));
            chk("rsp_au_b",      64'(bus.au_b),      64'(e.b));
`ifdef ADDSUB_ARB_OVF_EN
            chk("rsp_ovf",       64'(bus.rsp_ovf),   64'(e.ovf));
`endif
          end
        end
        prev_rv = bus.rsp_valid;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;
    rst_n = 1'b0;
    rr    = '1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_y",     64'(bus.rsp_y),     64'd0);
    chk("rst_au_a",      64'(bus.au_a),      64'd0);
    chk("rst_au_b",      64'(bus.au_b),      64'd0);
    chk("rst_au_sr",     64'(bus.au_sr),     64'd0);
`ifdef ADDSUB_ARB_OVF_EN
    chk("rst_rsp_ovf",   64'(bus.rsp_ovf),   64'd0);
`endif
    rst_n = 1'b1;

    // Single add, then subtract and add wrap
    send(0, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 0, 1'b1);
    drain();
    send(1, 32'd3, 32'd5, 1'b1, 32'hFFFFFFFE, 1'b0, 0, 1'b1);
    drain();
    send(2, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b0, 0, 1'b1);
    drain();

    // All four requesters from reset: grants 0,1,2,3,0 every 3 cycles
    do_reset();
    send(0, 32'd10,        32'd20,        1'b0, 32'd30,        1'b0, 0, 1'b1);
    send(1, 32'd100,       32'd1,         1'b1, 32'd99,        1'b0, 3, 1'b1);
    send(2, 32'h12345678,  32'h11111111,  1'b0, 32'h23456789,  1'b0, 3, 1'b1);
    send(3, 32'd0,         32'd1,         1'b1, 32'hFFFFFFFF,  1'b0, 3, 1'b1);
    send(0, 32'h80000000,  32'h80000000,  1'b0, 32'd0,         1'b1, 3, 1'b1);
    drain();

    // Backpressure on requester 2 while 3 and 0 wait; next grant is 3
    rr = 4'b1011;
    send(2, 32'h40000000, 32'h40000000, 1'b0, 32'h80000000, 1'b1, 0, 1'b1);
    n = 0;
    while (!bus.rsp_valid[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", 64'(bus.rsp_valid[2]), 64'd1);
    send(3, 32'h20,       32'h8,  1'b1, 32'h18, 1'b0, 0, 1'b1);
    send(0, 32'hFFFFFFF0, 32'h20, 1'b0, 32'h10, 1'b0, 0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'h4);
      chk("bp_rsp_y",     64'(bus.rsp_y),     64'h80000000);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk);
    #1 rr = '1;
    drain();

    // Reset during ISSUE: outputs clear at once, no response afterwards
    send(1, 32'h55, 32'h66, 1'b0, 32'hBB, 1'b0, 0, 1'b0);
    n = 0;
    while (!bus.req_ready[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_accept", 64'(bus.req_ready[1]), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("arst_rsp_y",     64'(bus.rsp_y),     64'd0);
    chk("arst_au_a",      64'(bus.au_a),      64'd0);
    chk("arst_au_b",      64'(bus.au_b),      64'd0);
    chk("arst_au_sr",     64'(bus.au_sr),     64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    aq.delete();
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | (|bus.rsp_valid);
    end
    chk("arst_no_rsp", 64'(seen), 64'd0);
    // Pointer back at 0: lowest valid index (1) wins over 3
    send(1, 32'h3E8,      32'h18, 1'b0, 32'h400,      1'b0, 0, 1'b1);
    send(3, 32'h80000000, 32'd1,  1'b1, 32'h7FFFFFFF, 1'b1, 0, 1'b1);
    drain();

    // Signed overflow corner cases
    send(0, 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b1, 0, 1'b1);
    drain();
    send(1, 32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 0, 1'b1);
    drain();
    send(2, 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 0, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
